// File: rtl/uart_tx_arbiter_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter.
// Bit timing is 26 clk per bit (250 kHz system clock, 9600 bps), 10-bit frames.
package uart_pkg;

    localparam int CLKS_PER_BIT       = 26;
    localparam int FRAME_BITS         = 10;
    localparam int FRAME_CLKS         = FRAME_BITS * CLKS_PER_BIT;
    // one idle bit time between frames
    localparam int DEF_GAP_CYCLES     = CLKS_PER_BIT;
    // one full frame plus a margin of 140 clk before the watchdog fires
    localparam int DEF_TIMEOUT_CYCLES = FRAME_CLKS + 140;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester handshake and transmitter control signals.
// slave = arbiter side, master = producers/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_stop;
    logic                 tx_active;
    logic                 tx_done;

    modport slave (
        input  req_valid, req_data, tx_active, tx_done,
        output req_ready, tx_start, tx_data, tx_stop
    );

    modport master (
        output req_valid, req_data, tx_active, tx_done,
        input  req_ready, tx_start, tx_data, tx_stop
    );
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin select: first set bit of req at or after ptr, wrapping.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    // scan NUM_REQ positions starting at ptr; the first hit wins
    always_comb begin
        int idx;
        logic [NUM_REQ-1:0] mask;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        mask      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx  = (int'(ptr) + k) % NUM_REQ;
            mask = NUM_REQ'(1) << idx;
            if (!any && (|(req & mask))) begin
                any       = 1'b1;
                grant_oh  = mask;
                grant_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte producers.
// Optional statistics counters (frame_cnt, drop_cnt) are built when the macro
// UART_ARB_STATS_EN is defined; the default build omits those ports.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame in flight; grant the next valid requester, if any
// LAUNCH    | one-cycle tx_start pulse; watchdog already running
// WAIT_DONE | frame in flight; wait for tx_done or watchdog terminal count
// GAP       | enforced idle time after a frame; no grants
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
`ifdef UART_ARB_STATS_EN
    ,
    output logic [15:0]                frame_cnt,
    output logic [7:0]                 drop_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // one down-counter serves as watchdog during a frame and as gap timer after it
    localparam int CNT_W = $clog2(max_int(max_int(TIMEOUT_CYCLES, GAP_CYCLES), 2));

    arb_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [7:0]         pick_byte;
    logic               grant_fire;
    logic               wd_expire;
    logic               frame_ok;
    logic [7:0]         tx_data_q;
    logic               unused_tx_active;

    // tx_active is informational only; completion is tracked through tx_done
    assign unused_tx_active = bus.tx_active;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // byte of the requester the picker selected
    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_byte = bus.req_data[8*i +: 8];
        end
    end

    // rst_n gates the grant so a held request is not accepted during reset
    assign grant_fire = rst_n && (state_q == IDLE) && pick_any;
    // tx_done on the terminal-count cycle wins over the watchdog
    assign frame_ok   = (state_q == WAIT_DONE) && bus.tx_done;
    assign wd_expire  = (state_q == WAIT_DONE) && !bus.tx_done && (cnt_q == '0);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pick_any) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_DONE;
            WAIT_DONE: if (frame_ok || wd_expire) state_d = GAP;
            GAP:       if (cnt_q == '0) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        bus.req_ready = grant_fire ? pick_oh : '0;
        bus.tx_start  = (state_q == LAUNCH);
        busy          = (state_q != IDLE);
    end

    assign bus.tx_stop = 1'b1;
    assign bus.tx_data = tx_data_q;

    // grant capture, round-robin pointer, watchdog/gap timer and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data_q   <= '0;
            grant_id    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        tx_data_q <= pick_byte;
                        grant_id  <= pick_idx;
                        ptr_q     <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        // counts the LAUNCH cycle as the first watchdog clock
                        cnt_q     <= CNT_W'(TIMEOUT_CYCLES - 1);
                    end
                end
                LAUNCH: cnt_q <= cnt_q - 1'b1;
                WAIT_DONE: begin
                    if (frame_ok || wd_expire) cnt_q <= CNT_W'(GAP_CYCLES - 1);
                    else                       cnt_q <= cnt_q - 1'b1;
                end
                GAP: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= '0;
            endcase
            if (wd_expire) timeout_err <= 1'b1;
        end
    end

`ifdef UART_ARB_STATS_EN
    // completed-frame count wraps; timeout count saturates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (frame_ok) frame_cnt <= frame_cnt + 1'b1;
            if (wd_expire && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a grant scoreboard.
// Stats checks are compiled when UART_ARB_STATS_EN is defined.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GAP_C   = 26;
    localparam int TMO_C   = 400;
    localparam int FRAME_C = 12;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;
`ifdef UART_ARB_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (GAP_C),
        .TIMEOUT_CYCLES (TMO_C)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
`ifdef UART_ARB_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        rst_n         = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // wait for an accept, compare against the scoreboard, optionally finish the frame
    task automatic serve_one(input int budget, input bit do_done, input bit drop);
        exp_t e;
        int   k;
        bit   got;
        got = 1'b0;
        k   = 0;
        while (k < budget) begin
            #1;
            if (bus.req_ready != '0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        check("accept_seen", 32'(got), 32'd1);
        if (!got || sb.size() == 0) return;
        e = sb.pop_front();
        check("req_ready_onehot", 32'(bus.req_ready), 32'(1) << e.id);
        @(negedge clk);
        if (drop) bus.req_valid[e.id] = 1'b0;
        #1;
        check("tx_start_launch", 32'(bus.tx_start), 32'd1);
        check("tx_data_launch", 32'(bus.tx_data), 32'(e.data));
        check("grant_id", 32'(grant_id), 32'(e.id));
        check("req_ready_launch", 32'(bus.req_ready), 32'd0);
        if (do_done) begin
            bus.tx_active = 1'b1;
            @(negedge clk);
            #1;
            check("tx_start_one_cycle", 32'(bus.tx_start), 32'd0);
            repeat (FRAME_C - 1) @(negedge clk);
            #1;
            check("tx_data_held", 32'(bus.tx_data), 32'(e.data));
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done   = 1'b0;
            bus.tx_active = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;

        // reset values
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_tx_stop", 32'(bus.tx_stop), 32'd1);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;

        // single requester 2, then the inter-frame gap before its next byte
        bus.req_data  = {8'h00, 8'hD1, 8'h00, 8'h00};
        bus.req_valid = 4'b0100;
        push_exp(2, 8'hD1);
        serve_one(200, 1'b1, 1'b1);
        bus.req_data[23:16] = 8'h5A;
        bus.req_valid       = 4'b0100;
        push_exp(2, 8'h5A);
        k = 0;
        while (k < 100) begin
            #1;
            if (bus.req_ready != '0) break;
            check("busy_in_gap", 32'(busy), 32'd1);
            @(negedge clk);
            k++;
        end
        check("gap_latency", 32'(k), 32'(GAP_C));
        serve_one(200, 1'b1, 1'b1);

        // all four valid continuously: order 0,1,2,3,0
        apply_reset();
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_valid = 4'b1111;
        push_exp(0, 8'h11);
        push_exp(1, 8'h22);
        push_exp(2, 8'h33);
        push_exp(3, 8'h44);
        push_exp(0, 8'h11);
        for (int i = 0; i < 5; i++) serve_one(200, 1'b1, 1'b0);
        bus.req_valid = '0;

        // pointer at 3 with requesters 0 and 2 valid: wrap to 0, then 2
        apply_reset();
        bus.req_data  = {8'h00, 8'h2C, 8'h00, 8'h00};
        bus.req_valid = 4'b0100;
        push_exp(2, 8'h2C);
        serve_one(200, 1'b1, 1'b1);
        bus.req_data  = {8'h00, 8'hB2, 8'h00, 8'hB0};
        bus.req_valid = 4'b0101;
        push_exp(0, 8'hB0);
        push_exp(2, 8'hB2);
        serve_one(200, 1'b1, 1'b0);
        serve_one(200, 1'b1, 1'b1);
        bus.req_valid = '0;

        // tx_done on the watchdog terminal cycle counts as done
        bus.req_data[15:8] = 8'h61;
        bus.req_valid      = 4'b0010;
        push_exp(1, 8'h61);
        serve_one(400, 1'b0, 1'b1);
        repeat (TMO_C - 1) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        #1;
        check("done_at_expiry_err", 32'(timeout_err), 32'd0);
        check("done_at_expiry_busy", 32'(busy), 32'd1);

        // spurious tx_done while idle is ignored
        repeat (GAP_C + 2) @(negedge clk);
        #1;
        check("idle_before_spurious", 32'(busy), 32'd0);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        #1;
        check("spurious_done_busy", 32'(busy), 32'd0);
        check("spurious_done_err", 32'(timeout_err), 32'd0);

        // watchdog expiry, gap, then the next request is still served
        bus.req_data[31:24] = 8'h77;
        bus.req_valid       = 4'b1000;
        push_exp(3, 8'h77);
        serve_one(200, 1'b0, 1'b1);
        k = 0;
        while (k < TMO_C + 20) begin
            @(negedge clk);
            k++;
            #1;
            if (timeout_err) break;
        end
        check("timeout_latency", 32'(k), 32'(TMO_C));
        k = 0;
        while (k < 100) begin
            if (!busy) break;
            @(negedge clk);
            k++;
            #1;
        end
        check("timeout_gap_len", 32'(k), 32'(GAP_C));
        bus.req_data[7:0] = 8'h3C;
        bus.req_valid     = 4'b0001;
        push_exp(0, 8'h3C);
        serve_one(200, 1'b1, 1'b1);
        #1;
        check("err_sticky", 32'(timeout_err), 32'd1);

        // reset in WAIT_DONE: everything back to reset values, pointer 0
        repeat (GAP_C + 2) @(negedge clk);
        bus.req_data[23:16] = 8'h99;
        bus.req_valid       = 4'b0100;
        push_exp(2, 8'h99);
        serve_one(200, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        bus.req_data[15:8]  = 8'h4B;
        bus.req_data[31:24] = 8'hE3;
        bus.req_valid       = 4'b1010;
        rst_n               = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_tx_start", 32'(bus.tx_start), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_tx_data", 32'(bus.tx_data), 32'd0);
        check("midrst_grant_id", 32'(grant_id), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(timeout_err), 32'd0);
        check("midrst_tx_stop", 32'(bus.tx_stop), 32'd1);
        rst_n = 1'b1;
        push_exp(1, 8'h4B);
        serve_one(200, 1'b1, 1'b1);
        bus.req_valid = '0;

`ifdef UART_ARB_STATS_EN
        // three completed frames and one timeout
        apply_reset();
        bus.req_data[7:0] = 8'hA5;
        bus.req_valid     = 4'b0001;
        for (int i = 0; i < 4; i++) push_exp(0, 8'hA5);
        for (int i = 0; i < 3; i++) serve_one(200, 1'b1, 1'b0);
        serve_one(200, 1'b0, 1'b1);
        k = 0;
        while (k < TMO_C + 100) begin
            @(negedge clk);
            k++;
            #1;
            if (!busy) break;
        end
        check("stats_idle", 32'(busy), 32'd0);
        check("stats_frame_cnt", 32'(frame_cnt), 32'd3);
        check("stats_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (start/data/stop in; active/done out; 26 clk per bit at 250 kHz / 9600 bps) between NUM_REQ byte producers. Round-robin arbitration, valid/ready handshake per requester, frame launch and completion tracking, and an inter-frame gap. Sits between the producers and the transmitter, alongside the receiver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 26, idle clocks enforced after tx_done before the next launch (one bit time)
TIMEOUT_CYCLES, 400, max clocks from launch to tx_done before abort (≥ 10 bits × 26 + margin)

Ports:
clk  in  1  system clock, 250 kHz
rst_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
tx_start  out  1  one-cycle launch pulse to transmitter
tx_data  out  8  byte to transmitter; held stable from launch until tx_done
tx_stop  out  1  stop-bit level; constant 1
tx_active  in  1  transmitter busy
tx_done  in  1  transmitter frame-complete pulse
grant_id  out  $clog2(NUM_REQ)  index of last/current granted requester
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- One clock clk; reset rst_n synchronous, active-low. Sampled on clk rising edge; rst_n=0 overrides all other inputs that cycle.
- Reset values: req_ready=0, tx_start=0, tx_data=0, tx_stop=1, grant_id=0, busy=0, timeout_err=0, rr pointer=0, state=IDLE.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE: if any req_valid, pick first valid index searching from (last grant + 1) mod NUM_REQ, wrapping. In the same cycle: req_ready[i]=1, latch req_data[i] into tx_data, grant_id=i, and go to LAUNCH. Requester i must deassert or change its data after seeing req_ready.
- LAUNCH: tx_start=1 for exactly one cycle; watchdog reset to 0; then go to WAIT_DONE.
- WAIT_DONE: wait for tx_done. tx_active is informational only. On tx_done, go to GAP with gap counter=0. Watchdog increments each cycle; at TIMEOUT_CYCLES-1 without tx_done, set timeout_err=1 and go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. No grant during GAP.
- Minimum cycle from accept to next accept: 1 + frame time + GAP_CYCLES + 1.
- Fairness: rr pointer updates only on grant. A requester holding valid continuously is served at least once every NUM_REQ frames.
- Simultaneous events: tx_done in the same cycle as watchdog expiry counts as done; timeout_err is not set. req_valid changes during LAUNCH, WAIT_DONE or GAP are ignored until IDLE.
- tx_done while in IDLE or GAP (spurious): ignored.
- Reset mid-frame: FSM returns to IDLE and tx_start drops immediately. The transmitter is not reset by this block, so GAP handling on the next launch is the system's responsibility.
- Exactly one req_ready bit high at a time, only in IDLE→LAUNCH cycle.

Optional Feature:
UART_ARB_STATS_EN
- Defined: adds output port frame_cnt[15:0], a wrapping count of frames ending in tx_done (timeouts excluded), reset to 0, updated on the tx_done cycle. Also adds output drop_cnt[7:0], which saturates at 255 and counts timeouts.
- Undefined: neither port nor counters exist; behaviour otherwise identical.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT_DONE, GAP)
  - CLKS_PER_BIT=26
  - FRAME_BITS=10
  - default TIMEOUT/GAP constants derived from these
- One sub-module: uart_rr_picker, a combinational round-robin priority select (req vector, pointer → one-hot grant, index, any).

Test Plan:
- Single requester 2 sends 8'hD1 after reset → req_ready[2] one pulse; tx_start one cycle later; tx_data=8'hD1 held; grant_id=2; next grant no earlier than 26 clk after tx_done.
- All four valid continuously, bytes 8'h11/22/33/44 → transmit order 0,1,2,3,0. Exactly one req_ready per frame.
- Pointer at 3; requesters 0 and 2 valid → grant 0 (wrap-around), then 2.
- tx_done never asserted → timeout_err=1 at launch+TIMEOUT_CYCLES; FSM reaches IDLE after GAP; next request still served.
- rst_n=0 mid-WAIT_DONE → next cycle all outputs at reset values, state IDLE, pointer 0.
- With UART_ARB_STATS_EN: 3 good frames + 1 timeout → frame_cnt=3, drop_cnt=1.
